id_stage: RTL and testbench

- Registered RV32I instruction-decode pipeline stage, sitting between instruction fetch and execute.
- Decodes all base formats (R/I/S/B/U/J) into register addresses, destination, immediate and control fields.
- Holds the result in a one-entry pipeline register with valid/ready handshakes on both sides.
- Detects load-use hazards and inserts one bubble. Supports flush on redirect.

---
 rtl/id_stage.sv | 198 +++++++++++++++++++
 tb/tb_id_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: registered RV32I decode stage between fetch and execute.
// Decodes the instruction word into register addresses, destination,
// sign-extended immediate and control fields. The result is held in a
// one-entry pipeline register with valid/ready handshakes on both sides.
// Load-use hazards stall the incoming instruction, and flush drops the
// held instruction together with any pending hazard.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid/ready  fetch-side handshake; in_inst/in_pc are the offered word
//   flush           discard held instruction and hazard state
//   out_valid/ready execute-side handshake
//   out_pc          PC of the held instruction
//   out_addrA/B     rs1/rs2 (0 when the format does not read them)
//   out_rd, rd_we   destination and write enable (never set for x0)
//   out_imm         sign-extended immediate (0 for R-type / illegal)
//   out_opcode/funct3/funct7  raw instruction fields
//   out_fmt         0 none/illegal, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J
//   out_illegal     unrecognised encoding
module id_stage #(
  parameter int RFW = 5,
  parameter int DW  = 32,
  parameter int IW  = 32,
  parameter int PCW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_inst,
  input  logic [PCW-1:0] in_pc,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PCW-1:0] out_pc,
  output logic [RFW-1:0] out_addrA,
  output logic [RFW-1:0] out_addrB,
  output logic [RFW-1:0] out_rd,
  output logic           out_rd_we,
  output logic [DW-1:0]  out_imm,
  output logic [4:0]     out_opcode,
  output logic [2:0]     out_funct3,
  output logic [6:0]     out_funct7,
  output logic [2:0]     out_fmt,
  output logic           out_illegal
);

  typedef enum logic [4:0] {
    OPC_LOAD   = 5'd0,
    OPC_OP_IMM = 5'd4,
    OPC_AUIPC  = 5'd5,
    OPC_STORE  = 5'd8,
    OPC_OP     = 5'd12,
    OPC_LUI    = 5'd13,
    OPC_BRANCH = 5'd24,
    OPC_JALR   = 5'd25,
    OPC_JAL    = 5'd27,
    OPC_SYSTEM = 5'd28
  } opc_e;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  logic [4:0]     opc;
  logic [RFW-1:0] f_rs1, f_rs2, f_rd;
  fmt_e           d_fmt;
  logic [RFW-1:0] d_addr_a, d_addr_b, d_rd;
  logic [DW-1:0]  d_imm;
  logic           d_rd_we;

  assign opc   = in_inst[6:2];
  assign f_rs1 = RFW'(in_inst[19:15]);
  assign f_rs2 = RFW'(in_inst[24:20]);
  assign f_rd  = RFW'(in_inst[11:7]);

  always_comb begin
    d_fmt = FMT_NONE;
    if (in_inst[1:0] == 2'b11) begin
      case (opc)
        OPC_OP:                                    d_fmt = FMT_R;
        OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_SYSTEM: d_fmt = FMT_I;
        OPC_STORE:                                 d_fmt = FMT_S;
        OPC_BRANCH:                                d_fmt = FMT_B;
        OPC_LUI, OPC_AUIPC:                        d_fmt = FMT_U;
        OPC_JAL:                                   d_fmt = FMT_J;
        default:                                   d_fmt = FMT_NONE;
      endcase
    end
  end

  // S/B encodings carry immediate bits in the rd slot, so rd is reported as 0.
  always_comb begin
    d_addr_a = '0;
    d_addr_b = '0;
    d_rd     = '0;
    d_imm    = '0;
    case (d_fmt)
      FMT_R: begin
        d_addr_a = f_rs1;
        d_addr_b = f_rs2;
        d_rd     = f_rd;
      end
      FMT_I: begin
        d_addr_a = f_rs1;
        d_rd     = f_rd;
        d_imm    = {{(DW-12){in_inst[31]}}, in_inst[31:20]};
      end
      FMT_S: begin
        d_addr_a = f_rs1;
        d_addr_b = f_rs2;
        d_imm    = {{(DW-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      FMT_B: begin
        d_addr_a = f_rs1;
        d_addr_b = f_rs2;
        d_imm    = {{(DW-13){in_inst[31]}}, in_inst[31], in_inst[7],
                    in_inst[30:25], in_inst[11:8], 1'b0};
      end
      FMT_U: begin
        d_rd  = f_rd;
        d_imm = {{(DW-32){in_inst[31]}}, in_inst[31:12], 12'b0};
      end
      FMT_J: begin
        d_rd  = f_rd;
        d_imm = {{(DW-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                 in_inst[20], in_inst[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign d_rd_we = (d_rd != '0);

  // Hazard tracking. Unused/illegal address fields are 0 and both tracked
  // registers are nonzero whenever they matter, so x0 never matches.
  logic [RFW-1:0] ld_rd;
  logic           held_load, dep_held, dep_ld, dep;
  logic           in_xfer, out_xfer;

  assign held_load = out_valid && out_rd_we && (out_opcode == OPC_LOAD);
  assign dep_held  = held_load && ((d_addr_a == out_rd) || (d_addr_b == out_rd));
  // ld_rd only stalls while another instruction occupies the stage: if the
  // stage emptied behind the LOAD, that empty cycle already is the bubble.
  assign dep_ld    = out_valid && (ld_rd != '0) &&
                     ((d_addr_a == ld_rd) || (d_addr_b == ld_rd));
  assign dep       = dep_held || dep_ld;

  assign in_ready = !rst && !flush && (!out_valid || out_ready) && !dep;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_addrA   <= '0;
      out_addrB   <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_imm     <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_fmt     <= '0;
      out_illegal <= 1'b0;
      ld_rd       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ld_rd     <= '0;
    end else begin
      ld_rd <= (out_xfer && held_load) ? out_rd : '0;
      if (in_xfer) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_addrA   <= d_addr_a;
        out_addrB   <= d_addr_b;
        out_rd      <= d_rd;
        out_rd_we   <= d_rd_we;
        out_imm     <= d_imm;
        out_opcode  <= opc;
        out_funct3  <= in_inst[14:12];
        out_funct7  <= in_inst[31:25];
        out_fmt     <= d_fmt;
        out_illegal <= (d_fmt == FMT_NONE);
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a fetch queue feeds instructions, a reference model
// decodes them from the ISA rules and tracks what the stage should hold,
// and a compare process checks every output on every falling edge.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_addrA;
  logic [4:0]  out_addrB;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_imm;
  logic [4:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  id_stage #(.RFW(5), .DW(32), .IW(32), .PCW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_addrA(out_addrA), .out_addrB(out_addrB), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_imm(out_imm), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_fmt(out_fmt),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  fmt;
    logic        ill;
    logic        is_load;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i, input logic [31:0] pc);
    dec_t d;
    int f;
    logic [4:0] op;
    op = i[6:2];
    f = 0;
    if (i[1:0] == 2'b11) begin
      case (op)
        5'd12:                   f = 1;
        5'd4, 5'd25, 5'd0, 5'd28: f = 2;
        5'd8:                    f = 3;
        5'd24:                   f = 4;
        5'd13, 5'd5:             f = 5;
        5'd27:                   f = 6;
        default:                 f = 0;
      endcase
    end
    d = '0;
    d.pc  = pc;
    d.opc = op;
    d.f3  = i[14:12];
    d.f7  = i[31:25];
    d.fmt = 3'(f);
    d.ill = (f == 0);
    d.a   = (f inside {1, 2, 3, 4}) ? i[19:15] : 5'd0;
    d.b   = (f inside {1, 3, 4})    ? i[24:20] : 5'd0;
    d.rd  = (f inside {1, 2, 5, 6}) ? i[11:7]  : 5'd0;
    d.we  = (d.rd != 5'd0);
    case (f)
      2:       d.imm = 32'($signed(i[31:20]));
      3:       d.imm = 32'($signed({i[31:25], i[11:7]}));
      4:       d.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      5:       d.imm = {i[31:12], 12'h000};
      6:       d.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: d.imm = 32'd0;
    endcase
    d.is_load = (f == 2) && (op == 5'd0);
    return d;
  endfunction

  logic   m_valid;
  dec_t   m_out;
  logic [4:0] m_ld;
  logic   started;

  // A consumer waits while a LOAD it reads is still in the stage, or while
  // the LOAD just left and some other instruction sits between them.
  function automatic logic model_blocks(input dec_t d);
    logic [4:0] busy [2];
    logic hit;
    busy[0] = (m_valid && m_out.is_load && m_out.we) ? m_out.rd : 5'd0;
    busy[1] = m_valid ? m_ld : 5'd0;
    hit = 1'b0;
    for (int unsigned k = 0; k < 2; k++)
      if (busy[k] != 5'd0 && (d.a == busy[k] || d.b == busy[k])) hit = 1'b1;
    return hit;
  endfunction

  initial begin
    dec_t  nd;
    logic  exp_rdy;
    started = 1'b0;
    m_valid = 1'b0;
    m_out   = '0;
    m_ld    = 5'd0;
    forever begin
      @(negedge clk);
      nd = decode(in_inst, in_pc);
      exp_rdy = !rst && !flush && (!m_valid || out_ready) && !model_blocks(nd);
      if (started) begin
        chk("in_ready",    32'(in_ready),    32'(exp_rdy));
        chk("out_valid",   32'(out_valid),   32'(m_valid));
        chk("out_pc",      out_pc,           m_out.pc);
        chk("out_addrA",   32'(out_addrA),   32'(m_out.a));
        chk("out_addrB",   32'(out_addrB),   32'(m_out.b));
        chk("out_rd",      32'(out_rd),      32'(m_out.rd));
        chk("out_rd_we",   32'(out_rd_we),   32'(m_out.we));
        chk("out_imm",     out_imm,          m_out.imm);
        chk("out_opcode",  32'(out_opcode),  32'(m_out.opc));
        chk("out_funct3",  32'(out_funct3),  32'(m_out.f3));
        chk("out_funct7",  32'(out_funct7),  32'(m_out.f7));
        chk("out_fmt",     32'(out_fmt),     32'(m_out.fmt));
        chk("out_illegal", 32'(out_illegal), 32'(m_out.ill));
      end
      if (rst) begin
        started = 1'b1;
        m_valid = 1'b0;
        m_out   = '0;
        m_ld    = 5'd0;
      end else if (flush) begin
        m_valid = 1'b0;
        m_ld    = 5'd0;
      end else begin
        m_ld = (m_valid && out_ready && m_out.is_load && m_out.we) ? m_out.rd : 5'd0;
        if (in_valid && exp_rdy) begin
          m_out   = nd;
          m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] fq_inst [$];
  logic [31:0] fq_pc   [$];
  logic [31:0] dq_pc   [$];
  int          dq_cyc  [$];
  logic [31:0] next_pc = 32'h100;
  int          cyc = 0;

  task automatic present();
    if (fq_inst.size() > 0) begin
      in_valid = 1'b1;
      in_inst  = fq_inst[0];
      in_pc    = fq_pc[0];
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic push(input logic [31:0] inst);
    fq_inst.push_back(inst);
    fq_pc.push_back(next_pc);
    next_pc = next_pc + 32'd4;
    present();
  endtask

  task automatic tick();
    logic fire;
    @(negedge clk);
    fire = in_valid && in_ready;
    if (out_valid && out_ready && !rst && !flush) begin
      dq_pc.push_back(out_pc);
      dq_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
    if (fire) begin
      void'(fq_inst.pop_front());
      void'(fq_pc.pop_front());
    end
    present();
  endtask

  task automatic wait_out(input logic [31:0] pc, input string nm);
    int n;
    n = 0;
    while (!(out_valid === 1'b1 && out_pc === pc) && n < 30) begin
      tick();
      n++;
    end
    chk(nm, 32'(out_valid === 1'b1 && out_pc === pc), 32'd1);
  endtask

  task automatic clear_log();
    dq_pc.delete();
    dq_cyc.delete();
  endtask

  function automatic logic [31:0] addi(input int unsigned rd, input int unsigned imm);
    return (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0;

    // Reset
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    rst = 1'b0;
    tick();

    // ADDI x1,x2,-1
    push(32'hFFF10093);
    wait_out(32'h100, "addi_arrive");
    chk("addi_fmt", 32'(out_fmt), 32'd2);
    chk("addi_addrA", 32'(out_addrA), 32'd2);
    chk("addi_addrB", 32'(out_addrB), 32'd0);
    chk("addi_rd", 32'(out_rd), 32'd1);
    chk("addi_rd_we", 32'(out_rd_we), 32'd1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);

    // LUI x5,0x12345 ; BEQ x1,x2,-4
    push(32'h123452B7);
    push(32'hFE208EE3);
    wait_out(32'h104, "lui_arrive");
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_fmt", 32'(out_fmt), 32'd5);
    chk("lui_addrA", 32'(out_addrA), 32'd0);
    chk("lui_rd_we", 32'(out_rd_we), 32'd1);
    wait_out(32'h108, "beq_arrive");
    chk("beq_fmt", 32'(out_fmt), 32'd4);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_rd_we", 32'(out_rd_we), 32'd0);
    chk("beq_addrB", 32'(out_addrB), 32'd2);
    repeat (2) tick();

    // Backpressure: 4 ADDIs, execute stalls for three cycles
    clear_log();
    for (int unsigned i = 1; i <= 4; i++) push(addi(i, i));
    for (int k = 0; k < 10; k++) begin
      out_ready = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
      if (k == 2) begin
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_frozen_pc", out_pc, 32'h10C);
      end
      tick();
    end
    chk("stream_count", 32'(dq_pc.size()), 32'd4);
    for (int i = 0; i < 4 && i < dq_pc.size(); i++)
      chk("stream_order", dq_pc[i], 32'h10C + 32'(4 * i));

    // LW x3 then dependent ADD x4,x3,x2: one bubble
    clear_log();
    push(32'h0000A183);
    push(32'h00218233);
    repeat (8) tick();
    chk("lu_count", 32'(dq_pc.size()), 32'd2);
    if (dq_cyc.size() == 2) chk("lu_gap", 32'(dq_cyc[1] - dq_cyc[0]), 32'd2);

    // LW x3 then independent ADD x4,x5,x2: back to back
    clear_log();
    push(32'h0000A183);
    push(32'h00228233);
    repeat (8) tick();
    chk("nolu_count", 32'(dq_pc.size()), 32'd2);
    if (dq_cyc.size() == 2) chk("nolu_gap", 32'(dq_cyc[1] - dq_cyc[0]), 32'd1);

    // LW x3, ADDI x6, ADD x4,x3,x2: one bubble behind the ADDI
    clear_log();
    push(32'h0000A183);
    push(32'h00100313);
    push(32'h00218233);
    repeat (10) tick();
    chk("lu2_count", 32'(dq_pc.size()), 32'd3);
    if (dq_cyc.size() == 3) chk("lu2_gap", 32'(dq_cyc[2] - dq_cyc[0]), 32'd3);

    // Illegal word then ADDI x0
    push(32'h00000000);
    push(32'h00000013);
    wait_out(32'h138, "ill_arrive");
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_fmt", 32'(out_fmt), 32'd0);
    chk("ill_rd_we", 32'(out_rd_we), 32'd0);
    wait_out(32'h13C, "nop_arrive");
    chk("nop_flag", 32'(out_illegal), 32'd0);
    chk("nop_fmt", 32'(out_fmt), 32'd2);
    chk("nop_rd_we", 32'(out_rd_we), 32'd0);
    repeat (2) tick();

    // Flush while a LOAD is held and its consumer waits
    out_ready = 1'b0;
    push(32'h0000A183);
    push(32'h00218233);
    wait_out(32'h140, "fl_load_arrive");
    tick();
    chk("fl_dep_wait", 32'(in_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("fl_dep_valid", 32'(out_valid), 32'd1);
    chk("fl_dep_pc", out_pc, 32'h144);
    repeat (2) tick();

    // Reset in the middle of a stream
    push(addi(7, 7));
    push(addi(8, 8));
    push(addi(9, 9));
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_pc", out_pc, 32'd0);
    chk("mrst_out_imm", out_imm, 32'd0);
    chk("mrst_out_rd", 32'(out_rd), 32'd0);
    chk("mrst_out_fmt", 32'(out_fmt), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
